hamm_dec_io: RTL and testbench
==============================

// Module: hamm_dec_io
// PURPOSE
//  Memory-mapped IO peripheral: receive end of the CPU's hamm (Hamming encode) instruction.
//  CPU sw's 12-bit Hamming(12,8) codewords into an input FIFO. A 2-stage pipeline computes
//  the syndrome, corrects single-bit errors and queues results in an output FIFO.
//  CPU lw's results back and reads status/error counters. Sits on the IO bus beside the data memory.
// PARAMETERS
//  FIFO_DEPTH  4  entries per FIFO; power of 2, range 2..8
// PORTS
//  clock     in   1   system clock, all state on rising edge
//  reset     in   1   synchronous, active-high; clears all state
//  io_sel    in   1   chip select from address decode
//  io_addr   in   2   word offset (addr[3:2])
//  io_we     in   1   write strobe (qualified by io_sel)
//  io_re     in   1   read strobe; pops result FIFO on offset 0 (qualified by io_sel)
//  io_wdata  in   32  write data
//  io_rdata  out  32  combinational read data; 0 when io_sel=0 or offset 3
//  irq       out  1   registered; 1 while result FIFO non-empty
// BEHAVIOUR
//  Codeword: io_wdata[i-1] = position i (1..12). Parity at 1,2,4,8. Data d0..d7 at 3,5,6,7,9,10,11,12.
//  Reg map:
//   off0 W: push wdata[11:0] (+[12] if SECDED). Dropped if in FIFO full; sets OVF.
//   off0 R: result FIFO head = {valid[31],0,uncorr[17],corr[16],0,syn[11:8],data[7:0]}. io_re pops.
//     Empty: read 0, sets UDF.
//   off1 R: {0,out_cnt[11:8],in_cnt[7:4],UDF[3],OVF[2],in_full[1],out_nonempty[0]}. W wdata[0]=1: clr OVF,UDF.
//   off2 R: {uncorr_cnt[31:16],corr_cnt[15:0]}, 16-bit saturating. W (any data): clear both.
//  Pipeline:
//   S1 issues when in FIFO non-empty and out_cnt + in-flight < FIFO_DEPTH (credit check).
//     Pops and registers codeword and syndrome s = XOR of positions of set bits.
//   S2 corrects and writes result FIFO.
//   Latency: push at edge N into empty block -> result at head, irq=1 after edge N+2.
//   Throughput 1/cycle while credits allow. No result is ever dropped.
//  Decode (no SECDED):
//   s=0: clean, corr=0.
//   s=1..12: flip position s, corr=1.
//   s=13..15: uncorr=1, data extracted uncorrected.
//  Counters increment at S2 on corr / uncorr.
//  Simultaneous events:
//   push + S1 pop on full in FIFO: push dropped (full uses registered count).
//   io_re pop + S2 write same cycle: both occur, out_cnt unchanged.
//   Clear + increment same cycle: clear wins.
//  Reset: FIFOs, pipeline, flags, counters -> 0; irq=0. Mid-operation reset discards in-flight words.
//  io_we and io_re both set on off0: write offset pushes, read pops; independent.
// CONFIGURATION
//  HAMM_SECDED_EN defined: position 13 = wdata[12], overall even parity over 1..13.
//   Let pf = overall parity fail.
//   s=0 & !pf: clean.
//   pf & s<=12: single error, correct (s=0: parity bit only, data unchanged), corr=1.
//   !pf & s!=0: double error, uncorr=1, no flip.
//   pf & s>12: uncorr=1.
//  Not defined: wdata[12] ignored; decode per BEHAVIOUR.
// TESTING
//  1. Clean: write 0x0A27 @off0; 2 cycles later irq=1; read off0 -> 0x800000A5; irq=0; corr_cnt=0.
//  2. Single: write 0x0A07 (pos 6 flipped) -> 0x800106A5; off2 -> 0x00000001.
//  3. Double (pos 3,6): write 0x0A03.
//     SECDED -> 0x800205A0, uncorr_cnt=1. No SECDED -> 0x800105A2 (miscorrect).
//  4. Overflow, DEPTH=4: 9 back-to-back pushes, no reads -> 8 accepted, OVF=1, out_cnt=4, in_cnt=4.
//     Drain: 8 results, 9th read returns 0 with UDF=1. Write off1=1 clears flags.
//  5. Reset mid-stream: 3 pushes, reset on 2nd cycle -> status=0, irq=0, counters 0, read returns 0.
//  6. Concurrent: read pop and S2 write same cycle with out_cnt=2 -> out_cnt stays 2, order preserved.

Source files
------------

// File: rtl/hamm_dec_io_if.sv
// IO bus bundle between the CPU address decode and the Hamming receive peripheral.
// Latency: none (wires only).
// Backpressure: none on the bus; the peripheral drops pushes when full and flags it.
interface hamm_dec_io_if;
  logic        io_sel;
  logic [1:0]  io_addr;
  logic        io_we;
  logic        io_re;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        irq;

  modport master (output io_sel, io_addr, io_we, io_re, io_wdata, input io_rdata, irq);
  modport slave  (input io_sel, io_addr, io_we, io_re, io_wdata, output io_rdata, irq);
endinterface

// File: rtl/hamm_dec_io.sv
// Hamming(12,8) receive peripheral: input FIFO -> syndrome stage -> correct stage -> result FIFO.
// Latency: push at edge N reaches the result head (irq=1) after edge N+2; 1 word/cycle.
// Backpressure: S1 issues only with result-FIFO credit; full input drops pushes (OVF).
// Option: define HAMM_SECDED_EN for SECDED decode using position 13 as overall parity.
module hamm_dec_io #(
  parameter int FIFO_DEPTH = 4
) (
  input logic           clock,
  input logic           reset,
  hamm_dec_io_if.slave  bus
);
`ifdef HAMM_SECDED_EN
  localparam int CWW = 13;
`else
  localparam int CWW = 12;
`endif
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // Syndrome: XOR of the positions (1..12) of every set bit.
  function automatic logic [3:0] syndrome(input logic [11:0] w);
    logic [3:0] s;
    s = '0;
    for (int i = 1; i <= 12; i++)
      if (w[i-1]) s = s ^ 4'(i);
    return s;
  endfunction

  // Data bits d0..d7 live at positions 3,5,6,7,9,10,11,12.
  function automatic logic [7:0] extract(input logic [11:0] w);
    return {w[11], w[10], w[9], w[8], w[6], w[5], w[4], w[2]};
  endfunction

  logic [CWW-1:0] in_mem [FIFO_DEPTH];
  logic [AW-1:0]  in_wp, in_rp;
  logic [CW-1:0]  in_cnt;
  logic           s1_vld;
  logic [CWW-1:0] s1_cw;
  logic [3:0]     s1_syn;
  logic [13:0]    out_mem [FIFO_DEPTH];   // {uncorr, corr, syn[3:0], data[7:0]}
  logic [AW-1:0]  out_wp, out_rp;
  logic [CW-1:0]  out_cnt, out_cnt_nxt;
  logic           ovf, udf;
  logic [15:0]    corr_cnt, uncorr_cnt;
  logic [11:0]    s2_fix;
  logic           s2_corr, s2_uncorr;
  logic [CW:0]    inflight;

  wire acc0      = bus.io_sel && (bus.io_addr == 2'd0);
  wire push_req  = acc0 && bus.io_we;
  wire pop_req   = acc0 && bus.io_re;
  wire in_full   = (in_cnt == DEPTH_C);
  wire out_ne    = (out_cnt != '0);
  wire push      = push_req && !in_full;
  wire out_pop   = pop_req && out_ne;
  wire clr_flags = bus.io_sel && bus.io_we && (bus.io_addr == 2'd1) && bus.io_wdata[0];
  wire clr_cnts  = bus.io_sel && bus.io_we && (bus.io_addr == 2'd2);
  wire unused_wdata = ^bus.io_wdata[31:CWW];

  // Credit: result slots already used plus the word sitting in S1 must leave room.
  assign inflight    = {1'b0, out_cnt} + {{CW{1'b0}}, s1_vld};
  wire   issue       = (in_cnt != '0) && (inflight < {1'b0, DEPTH_C});
  assign out_cnt_nxt = out_cnt + CW'(s1_vld) - CW'(out_pop);

  // Input FIFO: accept CPU pushes, hand the head to S1 on issue.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_wp  <= '0;
      in_rp  <= '0;
      in_cnt <= '0;
    end else begin
      if (push) begin
        in_mem[in_wp] <= bus.io_wdata[CWW-1:0];
        in_wp         <= in_wp + 1'b1;
      end
      if (issue) in_rp <= in_rp + 1'b1;
      in_cnt <= in_cnt + CW'(push) - CW'(issue);
    end
  end

  // S1: register the codeword together with its syndrome.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s1_cw  <= '0;
      s1_syn <= '0;
    end else begin
      s1_vld <= issue;
      if (issue) begin
        s1_cw  <= in_mem[in_rp];
        s1_syn <= syndrome(in_mem[in_rp][11:0]);
      end
    end
  end

  // S2: decide correct / uncorrectable and flip the indicated position.
  always_comb begin
    logic flip;
    s2_fix    = s1_cw[11:0];
    s2_corr   = 1'b0;
    s2_uncorr = 1'b0;
    flip      = 1'b0;
`ifdef HAMM_SECDED_EN
    if (^s1_cw) begin
      // odd overall parity: single error (syn 0 means the parity bit itself)
      if (s1_syn <= 4'd12) begin
        s2_corr = 1'b1;
        flip    = (s1_syn != 4'd0);
      end else begin
        s2_uncorr = 1'b1;
      end
    end else if (s1_syn != 4'd0) begin
      s2_uncorr = 1'b1;
    end
`else
    if (s1_syn > 4'd12) begin
      s2_uncorr = 1'b1;
    end else if (s1_syn != 4'd0) begin
      s2_corr = 1'b1;
      flip    = 1'b1;
    end
`endif
    for (int i = 1; i <= 12; i++)
      if (flip && (s1_syn == 4'(i))) s2_fix[i-1] = ~s2_fix[i-1];
  end

  // Result FIFO: S2 writes (credit guarantees room), CPU read at offset 0 pops.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_wp  <= '0;
      out_rp  <= '0;
      out_cnt <= '0;
    end else begin
      if (s1_vld) begin
        out_mem[out_wp] <= {s2_uncorr, s2_corr, s1_syn, extract(s2_fix)};
        out_wp          <= out_wp + 1'b1;
      end
      if (out_pop) out_rp <= out_rp + 1'b1;
      out_cnt <= out_cnt_nxt;
    end
  end

  // Sticky overflow/underflow flags; a clear in the same cycle wins.
  always_ff @(posedge clock) begin
    if (reset || clr_flags) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (push_req && in_full) ovf <= 1'b1;
      if (pop_req && !out_ne)  udf <= 1'b1;
    end
  end

  // Saturating correction counters; a clear in the same cycle wins.
  always_ff @(posedge clock) begin
    if (reset || clr_cnts) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (s1_vld) begin
      if (s2_corr && (corr_cnt != 16'hFFFF))     corr_cnt   <= corr_cnt + 16'd1;
      if (s2_uncorr && (uncorr_cnt != 16'hFFFF)) uncorr_cnt <= uncorr_cnt + 16'd1;
    end
  end

  // Interrupt follows the next-state occupancy so it rises with the write.
  always_ff @(posedge clock) begin
    if (reset) bus.irq <= 1'b0;
    else       bus.irq <= (out_cnt_nxt != '0);
  end

  // Read mux.
  always_comb begin
    bus.io_rdata = '0;
    if (bus.io_sel) begin
      case (bus.io_addr)
        2'd0: if (out_ne)
                bus.io_rdata = {1'b1, 13'b0, out_mem[out_rp][13:12], 4'b0, out_mem[out_rp][11:0]};
        2'd1: bus.io_rdata = {20'b0, 4'(out_cnt), 4'(in_cnt), udf, ovf, in_full, out_ne};
        2'd2: bus.io_rdata = {uncorr_cnt, corr_cnt};
        default: bus.io_rdata = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_hamm_dec_io.sv
// Bench for hamm_dec_io: directed register-map scenarios plus random error injection.
// Expected results come from a reference built on encode + known injected errors.
// Define HAMM_SECDED_EN for both files to exercise the SECDED build.
module tb_hamm_dec_io;
  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;
  logic [31:0] exp_q[$];
  int   mdl_corr, mdl_uncorr;

  localparam int DPOS [8] = '{3, 5, 6, 7, 9, 10, 11, 12};

  hamm_dec_io_if bus();
  hamm_dec_io #(.FIFO_DEPTH(4)) dut (.clock(clock), .reset(reset), .bus(bus));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic logic [12:0] encode(input logic [7:0] d, input logic b13);
    logic [12:0] w;
    logic par;
    w = '0;
    for (int k = 0; k < 8; k++) w[DPOS[k]-1] = d[k];
    for (int p = 1; p <= 8; p = p * 2) begin
      par = 1'b0;
      for (int j = 1; j <= 12; j++)
        if (((j & p) != 0) && (j != p)) par = par ^ w[j-1];
      w[p-1] = par;
    end
`ifdef HAMM_SECDED_EN
    w[12] = ^w[11:0];
`else
    w[12] = b13;
`endif
    return w;
  endfunction

  function automatic logic [7:0] xdata(input logic [12:0] w);
    logic [7:0] d;
    for (int k = 0; k < 8; k++) d[k] = w[DPOS[k]-1];
    return d;
  endfunction

  // Expected result from the original byte and which positions were damaged.
  function automatic logic [31:0] predict(input logic [7:0] d, input logic [12:0] w,
                                          input int nerr, input int p, input int q);
    logic [3:0] s; logic c, u; logic [7:0] dd; logic [12:0] f;
    int sp, sq;
    s = '0; c = 1'b0; u = 1'b0; dd = d; f = w;
`ifdef HAMM_SECDED_EN
    sp = (p == 13) ? 0 : p;
    sq = (q == 13) ? 0 : q;
    if (nerr == 1) begin s = 4'(sp); c = 1'b1; end
    else if (nerr == 2) begin s = 4'(sp ^ sq); u = 1'b1; dd = xdata(w); end
`else
    sp = p; sq = q;
    if (nerr == 1) begin s = 4'(p); c = 1'b1; end
    else if (nerr == 2) begin
      s = 4'(sp ^ sq);
      if ((sp ^ sq) <= 12) begin f[(sp ^ sq)-1] = ~f[(sp ^ sq)-1]; c = 1'b1; end
      else u = 1'b1;
      dd = xdata(f);
    end
`endif
    return {1'b1, 13'b0, u, c, 4'b0, s, dd};
  endfunction

  task automatic idle();
    bus.io_sel = 1'b0; bus.io_addr = 2'd0; bus.io_we = 1'b0; bus.io_re = 1'b0; bus.io_wdata = '0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.io_sel = 1'b1; bus.io_addr = a; bus.io_we = 1'b1; bus.io_re = 1'b0; bus.io_wdata = d;
    @(posedge clock); #1; idle();
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.io_sel = 1'b1; bus.io_addr = a; bus.io_we = 1'b0; bus.io_re = 1'b1;
    @(negedge clock); d = bus.io_rdata;
    @(posedge clock); #1; idle();
  endtask

  task automatic op(input logic psh, input logic [12:0] w, input logic pop);
    bus.io_sel = psh | pop; bus.io_addr = 2'd0; bus.io_we = psh; bus.io_re = pop;
    bus.io_wdata = {19'b0, w};
    @(posedge clock); #1; idle();
  endtask

  task automatic wait_irq(input string name, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.irq) begin ok = 1'b1; break; end
      @(posedge clock); #1;
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL %s: irq never rose within 30 cycles, got 0 expected 1", name);
    end
  endtask

  // Monitor: every offset-0 read is compared against the oldest expected result.
  always @(negedge clock) begin
    if (!reset && bus.io_sel && bus.io_re && (bus.io_addr == 2'd0)) begin
      if (exp_q.size() > 0) check("head_read", bus.io_rdata, exp_q.pop_front());
      else                  check("empty_read", bus.io_rdata, 32'h0);
    end
  end

  initial begin
    logic [31:0] r;
    logic [7:0]  d;
    logic [12:0] w;
    logic        ok, psh, pop;
    int          nerr, p, q, npos;
    vectors = 0; miscompares = 0; mdl_corr = 0; mdl_uncorr = 0;
    idle();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    check("rst_irq", {31'b0, bus.irq}, 32'h0);
    rd(2'd1, r); check("rst_status", r, 32'h0);
    rd(2'd2, r); check("rst_counters", r, 32'h0);
    rd(2'd0, r);
    rd(2'd1, r); check("udf_set", r, 32'h8);
    wr(2'd1, 32'h1);
    rd(2'd1, r); check("flags_clr", r, 32'h0);

    // Clean word with latency check
    exp_q.push_back(32'h800000A5);
    wr(2'd0, 32'h0A27);
    check("irq_n", {31'b0, bus.irq}, 32'h0);
    @(posedge clock); #1; check("irq_n1", {31'b0, bus.irq}, 32'h0);
    @(posedge clock); #1; check("irq_n2", {31'b0, bus.irq}, 32'h1);
    rd(2'd0, r);
    check("irq_after_pop", {31'b0, bus.irq}, 32'h0);
    rd(2'd2, r); check("cnt_clean", r, 32'h0);

    // Single error at position 6
    exp_q.push_back(32'h800106A5);
    wr(2'd0, 32'h0A07);
    wait_irq("single", ok); rd(2'd0, r);
    rd(2'd2, r); check("cnt_single", r, 32'h1);

    // Double error at positions 3 and 6
`ifdef HAMM_SECDED_EN
    exp_q.push_back(32'h800205A0);
`else
    exp_q.push_back(32'h800105A2);
`endif
    wr(2'd0, 32'h0A03);
    wait_irq("double", ok); rd(2'd0, r);
    rd(2'd2, r);
`ifdef HAMM_SECDED_EN
    check("cnt_double", r, 32'h00010001);
`else
    check("cnt_double", r, 32'h00000002);
`endif

    // Reset in the middle of a burst discards everything
    wr(2'd0, 32'h0A27);
    reset = 1'b1;
    wr(2'd0, 32'h0A07);
    wr(2'd0, 32'h0A03);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("mid_rst_irq", {31'b0, bus.irq}, 32'h0);
    rd(2'd1, r); check("mid_rst_status", r, 32'h0);
    rd(2'd2, r); check("mid_rst_counters", r, 32'h0);
    rd(2'd0, r); check("mid_rst_read", r, 32'h0);
    wr(2'd1, 32'h1);

    // Overflow: 9 back-to-back pushes, only 8 fit
    for (int i = 0; i < 9; i++) begin
      d = 8'($urandom);
      w = encode(d, 1'b0);
      if (i < 8) exp_q.push_back(predict(d, w, 0, 0, 0));
      wr(2'd0, {19'b0, w});
    end
    rd(2'd1, r); check("ovf_status", r, 32'h447);
    for (int i = 0; i < 8; i++) begin
      wait_irq("ovf_drain", ok);
      if (ok) rd(2'd0, r);
    end
    rd(2'd0, r); check("ovf_9th_read", r, 32'h0);
    rd(2'd1, r); check("ovf_udf_status", r, 32'hC);
    wr(2'd1, 32'h1);
    rd(2'd1, r); check("ovf_flags_clr", r, 32'h0);

    // Pop and S2 write in the same cycle with two results queued
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      w = encode(d, 1'b1);
      exp_q.push_back(predict(d, w, 0, 0, 0));
      wr(2'd0, {19'b0, w});
    end
    @(posedge clock); #1;
    rd(2'd0, r);
    rd(2'd1, r); check("concurrent_status", r, 32'h201);
    for (int i = 0; i < 2; i++) begin
      wait_irq("concurrent_drain", ok);
      if (ok) rd(2'd0, r);
    end

    // Random traffic with 0, 1 or 2 injected errors
    wr(2'd2, 32'h0);
    mdl_corr = 0; mdl_uncorr = 0;
`ifdef HAMM_SECDED_EN
    npos = 13;
`else
    npos = 12;
`endif
    for (int i = 0; i < 400; i++) begin
      psh = (exp_q.size() < 4) && ($urandom_range(0, 2) != 0);
      pop = bus.irq && ($urandom_range(0, 2) != 0);
      w = '0;
      if (psh) begin
        d = 8'($urandom);
        w = encode(d, 1'($urandom));
        nerr = $urandom_range(0, 2);
        p = $urandom_range(1, npos);
        q = $urandom_range(1, npos);
        while (q == p) q = $urandom_range(1, npos);
        if (nerr >= 1) w[p-1] = ~w[p-1];
        if (nerr == 2) w[q-1] = ~w[q-1];
        r = predict(d, w, nerr, p, q);
        if (r[16]) mdl_corr++;
        if (r[17]) mdl_uncorr++;
        exp_q.push_back(r);
      end
      op(psh, w, pop);
    end
    while (exp_q.size() > 0) begin
      wait_irq("final_drain", ok);
      if (!ok) break;
      rd(2'd0, r);
    end
    rd(2'd2, r); check("random_counters", r, {16'(mdl_uncorr), 16'(mdl_corr)});
    rd(2'd1, r); check("final_status", r, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
